rx_frontend_dco: RTL

Receive-side ADC front end, the mirror of the transmit DAC front end. It does four things in a strobed pipeline between the ADC interface and the DDC:
- takes two raw ADC lanes and applies an I/Q swap/invert mux;
- left-justifies the samples to 24 bits;
- removes DC with a per-channel adaptive integrator loop, or a frozen/loaded offset;
- applies IQ balance correction.
All control comes through the standard settings bus.

---
 rtl/rx_frontend_dco.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rx_frontend_dco.sv
// Receive ADC front end: lane mux/invert, 24-bit left-justify, adaptive DC removal,
// optional IQ balance correction, all configured through the settings bus.
`timescale 1ns/1ps
module rx_frontend_dco #(
  parameter int BASE      = 0,
  parameter int WIDTH_IN  = 16,
  parameter int DCO_SHIFT = 20,
  parameter bit IQCOMP_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_stb,
  input  logic [7:0]          set_addr,
  input  logic [31:0]         set_data,
  input  logic                run,
  input  logic [WIDTH_IN-1:0] adc_a,
  input  logic [WIDTH_IN-1:0] adc_b,
  input  logic                adc_stb,
  output logic [23:0]         i_out,
  output logic [23:0]         q_out,
  output logic                out_stb
);
  localparam int IW = 24 + DCO_SHIFT;

  function automatic logic [23:0] ljust(input logic [WIDTH_IN-1:0] v);
    logic [23:0] r;
    r = '0;
    r[23 -: WIDTH_IN] = v;
    return r;
  endfunction

  function automatic logic [23:0] neg_sat(input logic [23:0] v);
    return (v == 24'h800000) ? 24'h7FFFFF : (~v + 24'd1);
  endfunction

  function automatic logic [23:0] sat24(input logic [24:0] v);
    if (v[24] == v[23]) return v[23:0];
    return v[24] ? 24'h800000 : 24'h7FFFFF;
  endfunction

  logic [3:0]  ctrl_reg;
  logic        auto_reg [2];
  logic        load_reg [2];
  logic [23:0] val_reg [2];
  logic [17:0] mag_reg;
  logic [17:0] phase_reg;
  logic        unused_set_bits;

  assign unused_set_bits = ^set_data[29:24];

  // Load is a one-cycle pulse; everything else is stored state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg  <= '0;
      mag_reg   <= '0;
      phase_reg <= '0;
      for (int k = 0; k < 2; k++) begin
        auto_reg[k] <= 1'b0;
        load_reg[k] <= 1'b0;
        val_reg[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) load_reg[k] <= 1'b0;
      if (set_stb) begin
        if (set_addr == 8'(BASE)) ctrl_reg <= set_data[3:0];
        for (int k = 0; k < 2; k++) begin
          if (set_addr == 8'(BASE + 1 + k)) begin
            load_reg[k] <= set_data[31];
            auto_reg[k] <= set_data[30];
            val_reg[k]  <= set_data[23:0];
          end
        end
        if (set_addr == 8'(BASE + 3)) mag_reg <= set_data[17:0];
        if (set_addr == 8'(BASE + 4)) phase_reg <= set_data[17:0];
      end
    end
  end

  logic [WIDTH_IN-1:0] raw_i, raw_q;
  logic [23:0]         lj_i, lj_q;
  logic [23:0]         s1_next [2];
  logic [23:0]         s1_reg [2];
  logic                s1_stb_reg;

  always_comb begin
    raw_i      = ctrl_reg[0] ? adc_b : adc_a;
    raw_q      = ctrl_reg[0] ? adc_a : adc_b;
    lj_i       = ljust(raw_i);
    lj_q       = ljust(raw_q);
    s1_next[0] = ctrl_reg[1] ? neg_sat(lj_i) : lj_i;
    s1_next[1] = ctrl_reg[3] ? 24'd0 : (ctrl_reg[2] ? neg_sat(lj_q) : lj_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg[0]  <= '0;
      s1_reg[1]  <= '0;
      s1_stb_reg <= 1'b0;
    end else begin
      s1_reg[0]  <= s1_next[0];
      s1_reg[1]  <= s1_next[1];
      s1_stb_reg <= adc_stb;
    end
  end

  logic [23:0] y_dc [2];
  logic        s2_stb_reg;

  always_ff @(posedge clk) begin
    if (rst) s2_stb_reg <= 1'b0;
    else     s2_stb_reg <= s1_stb_reg;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_dc
    logic [IW-1:0] integ_reg;
    logic [23:0]   y_reg;
    logic [23:0]   est;
    logic [24:0]   diff;
    logic [23:0]   y;
    logic [IW:0]   acc;
    logic [IW-1:0] acc_sat;

    always_comb begin
      est  = integ_reg[IW-1:DCO_SHIFT];
      diff = {s1_reg[gi][23], s1_reg[gi]} - {est[23], est};
      y    = sat24(diff);
      acc  = {integ_reg[IW-1], integ_reg} + {{(DCO_SHIFT + 1){y[23]}}, y};
      if (acc[IW] != acc[IW-1])
        acc_sat = acc[IW] ? {1'b1, {(IW - 1){1'b0}}} : {1'b0, {(IW - 1){1'b1}}};
      else
        acc_sat = acc[IW-1:0];
    end

    // Load overrides the loop update when both land in the same cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        integ_reg <= '0;
        y_reg     <= '0;
      end else begin
        y_reg <= y;
        if (load_reg[gi])
          integ_reg <= {val_reg[gi], {DCO_SHIFT{1'b0}}};
        else if (auto_reg[gi] && run && s1_stb_reg)
          integ_reg <= acc_sat;
      end
    end

    assign y_dc[gi] = y_reg;
  end

  if (IQCOMP_EN) begin : g_iq
    logic signed [35:0] op_y, op_m, op_p;
    logic [35:0]        mi_reg, mq_reg;
    logic [23:0]        yi_dly_reg, yq_dly_reg;
    logic               s3_stb_reg;
    logic [23:0]        i_reg, q_reg;
    logic               s4_stb_reg;
    logic               unused_frac;

    assign op_y        = {{18{y_dc[0][23]}}, y_dc[0][23:6]};
    assign op_m        = {{18{mag_reg[17]}}, mag_reg};
    assign op_p        = {{18{phase_reg[17]}}, phase_reg};
    assign unused_frac = ^{mi_reg[11:0], mq_reg[11:0]};

    always_ff @(posedge clk) begin
      if (rst) begin
        mi_reg     <= '0;
        mq_reg     <= '0;
        yi_dly_reg <= '0;
        yq_dly_reg <= '0;
        s3_stb_reg <= 1'b0;
        i_reg      <= '0;
        q_reg      <= '0;
        s4_stb_reg <= 1'b0;
      end else begin
        mi_reg     <= op_y * op_m;
        mq_reg     <= op_y * op_p;
        yi_dly_reg <= y_dc[0];
        yq_dly_reg <= y_dc[1];
        s3_stb_reg <= s2_stb_reg;
        i_reg      <= sat24({yi_dly_reg[23], yi_dly_reg} + {mi_reg[35], mi_reg[35:12]});
        q_reg      <= sat24({yq_dly_reg[23], yq_dly_reg} + {mq_reg[35], mq_reg[35:12]});
        s4_stb_reg <= s3_stb_reg;
      end
    end

    assign i_out   = i_reg;
    assign q_out   = q_reg;
    assign out_stb = s4_stb_reg & run;
  end else begin : g_bypass
    logic unused_corr;
    assign unused_corr = ^{mag_reg, phase_reg};
    assign i_out   = y_dc[0];
    assign q_out   = y_dc[1];
    assign out_stb = s2_stb_reg & run;
  end
endmodule
